stopwatch_lap: RTL and testbench

Parametrised successor to the single-mode stopwatch. It is an up/down min:sec:centisecond timer with a preloadable start value and a countdown expiry flag. A small lap-capture FIFO records split times. It sits behind the AXI-lite register wrapper: cmd, dir and load_val come from control registers, and timer, lap and status outputs go to read-back registers.

---
 rtl/stopwatch_lap.sv | 166 ++++++++++++++++
 tb/tb_stopwatch_lap.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_lap.sv
// Up/down min:sec:centi stopwatch with preload, countdown expiry and a lap-capture FIFO.
// Optional STOPWATCH_BCD_OUT_EN presents timer and lap_data fields as packed BCD.
module stopwatch_lap #(
   parameter int TICK_DIV  = 250000,
   parameter int MIN_MAX   = 59,
   parameter int LAP_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic [1:0]                   cmd,
   input  logic                         dir,
   input  logic                         load,
   input  logic [23:0]                  load_val,
   output logic [23:0]                  timer,
   output logic                         running,
   output logic                         expired,
   output logic [23:0]                  lap_data,
   output logic                         lap_valid,
   input  logic                         lap_rd,
   output logic [$clog2(LAP_DEPTH):0]   lap_count,
   output logic                         lap_ovf
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int AW = $clog2(LAP_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [7:0] MIN_LIM = 8'(MIN_MAX);

   logic [TW-1:0] tick_q, tick_d;
   logic [7:0]    min_q, min_d, sec_q, sec_d, cen_q, cen_d;
   logic          expired_q, expired_d;
   logic [1:0]    prev_cmd_q;
   logic [23:0]   mem_q [LAP_DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;
   logic          ovf_q;

   logic clear, run_cmd, zero, terminal, lap_edge, pop, full, push;
   logic [23:0] timer_bin;

   function automatic logic [7:0] fld(input logic [7:0] v);
`ifdef STOPWATCH_BCD_OUT_EN
      return ((v / 8'd10) << 4) | (v % 8'd10);
`else
      return v;
`endif
   endfunction

   assign timer_bin = {min_q, sec_q, cen_q};
   assign clear     = (cmd == 2'd2);
   assign run_cmd   = (cmd == 2'd1) || (cmd == 2'd3);
   assign zero      = (timer_bin == 24'd0);
   assign running   = run_cmd && !(dir && zero);
   assign terminal  = (tick_q == TW'(TICK_DIV - 1));

   always_comb begin
      tick_d    = tick_q;
      min_d     = min_q;
      sec_d     = sec_q;
      cen_d     = cen_q;
      expired_d = expired_q;
      if (clear) begin
         tick_d    = '0;
         min_d     = 8'd0;
         sec_d     = 8'd0;
         cen_d     = 8'd0;
         expired_d = 1'b0;
      end else if (load) begin
         tick_d    = '0;
         min_d     = (load_val[23:16] > MIN_LIM) ? MIN_LIM : load_val[23:16];
         sec_d     = (load_val[15:8]  > 8'd59)   ? 8'd59   : load_val[15:8];
         cen_d     = (load_val[7:0]   > 8'd99)   ? 8'd99   : load_val[7:0];
         expired_d = 1'b0;
      end else if (running) begin
         if (!terminal) begin
            tick_d = tick_q + TW'(1);
         end else begin
            tick_d = '0;
            if (!dir) begin
               if (cen_q != 8'd99) begin
                  cen_d = cen_q + 8'd1;
               end else begin
                  cen_d = 8'd0;
                  if (sec_q != 8'd59) begin
                     sec_d = sec_q + 8'd1;
                  end else begin
                     sec_d = 8'd0;
                     min_d = (min_q == MIN_LIM) ? 8'd0 : min_q + 8'd1;
                  end
               end
            end else begin
               // running guarantees a nonzero timer here, so borrows never underflow
               if (cen_q != 8'd0) begin
                  cen_d = cen_q - 8'd1;
               end else begin
                  cen_d = 8'd99;
                  if (sec_q != 8'd0) begin
                     sec_d = sec_q - 8'd1;
                  end else begin
                     sec_d = 8'd59;
                     min_d = min_q - 8'd1;
                  end
               end
               if (timer_bin == 24'd1) expired_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tick_q    <= '0;
         min_q     <= 8'd0;
         sec_q     <= 8'd0;
         cen_q     <= 8'd0;
         expired_q <= 1'b0;
      end else begin
         tick_q    <= tick_d;
         min_q     <= min_d;
         sec_q     <= sec_d;
         cen_q     <= cen_d;
         expired_q <= expired_d;
      end
   end

   // Lap FIFO: lap_valid means the head on lap_data is real; lap_rd pops only while lap_valid.
   assign lap_edge = (cmd == 2'd3) && (prev_cmd_q != 2'd3);
   assign pop      = lap_rd && (cnt_q != '0);
   assign full     = (cnt_q == CW'(LAP_DEPTH));
   assign push     = lap_edge && (!full || pop);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         prev_cmd_q <= 2'd0;
         wr_q       <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         for (int i = 0; i < LAP_DEPTH; i++) mem_q[i] <= 24'd0;
      end else begin
         prev_cmd_q <= cmd;
         if (clear) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
         end else begin
            if (push) begin
               mem_q[wr_q] <= timer_bin;
               wr_q        <= wr_q + AW'(1);
            end
            if (pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
            if (lap_edge && full && !pop) ovf_q <= 1'b1;
         end
      end
   end

   assign timer     = {fld(min_q), fld(sec_q), fld(cen_q)};
   assign lap_data  = {fld(mem_q[rd_q][23:16]), fld(mem_q[rd_q][15:8]), fld(mem_q[rd_q][7:0])};
   assign lap_valid = (cnt_q != '0);
   assign lap_count = cnt_q;
   assign expired   = expired_q;
   assign lap_ovf   = ovf_q;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Bench for stopwatch_lap: vector table for timer behaviour, scoreboard queue for lap captures.
module tb_stopwatch_lap;

   logic        clk = 1'b0;
   logic        resetn;
   logic [1:0]  cmd;
   logic        dir;
   logic        load;
   logic [23:0] load_val;
   logic [23:0] timer;
   logic        running;
   logic        expired;
   logic [23:0] lap_data;
   logic        lap_valid;
   logic        lap_rd;
   logic [2:0]  lap_count;
   logic        lap_ovf;

   int n_total = 0;
   int n_pass  = 0;
   int n       = 0;
   logic [23:0] exp_q[$];
   logic [23:0] e;

   typedef struct {
      logic [1:0]  cmd;
      logic        dir;
      logic        load;
      logic [23:0] lv;
      int          ncyc;
      logic [23:0] t;
      logic        run;
      logic        exp;
   } vec_t;
   vec_t vecs[23];

   stopwatch_lap #(.TICK_DIV(4), .MIN_MAX(59), .LAP_DEPTH(4)) dut (
      .clk(clk), .resetn(resetn), .cmd(cmd), .dir(dir), .load(load), .load_val(load_val),
      .timer(timer), .running(running), .expired(expired), .lap_data(lap_data),
      .lap_valid(lap_valid), .lap_rd(lap_rd), .lap_count(lap_count), .lap_ovf(lap_ovf)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] f8(input logic [7:0] v);
`ifdef STOPWATCH_BCD_OUT_EN
      logic [7:0] t;
      logic [7:0] o;
      t = v / 8'd10;
      o = v % 8'd10;
      return {t[3:0], o[3:0]};
`else
      return v;
`endif
   endfunction

   function automatic logic [23:0] fmt(input logic [23:0] v);
      return {f8(v[23:16]), f8(v[15:8]), f8(v[7:0])};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask

   initial begin
      vecs[0]  = '{2'd0, 1'b0, 1'b0, 24'h0,          1,   24'h000000, 1'b0, 1'b0};
      vecs[1]  = '{2'd1, 1'b0, 1'b0, 24'h0,          400, 24'h000100, 1'b1, 1'b0};
      vecs[2]  = '{2'd2, 1'b0, 1'b0, 24'h0,          1,   24'h000000, 1'b0, 1'b0};
      vecs[3]  = '{2'd0, 1'b0, 1'b1, {8'd0,8'd59,8'd99},  1, {8'd0,8'd59,8'd99}, 1'b0, 1'b0};
      vecs[4]  = '{2'd1, 1'b0, 1'b0, 24'h0,          4,   {8'd1,8'd0,8'd0},   1'b1, 1'b0};
      vecs[5]  = '{2'd0, 1'b0, 1'b1, {8'd59,8'd59,8'd99}, 1, {8'd59,8'd59,8'd99}, 1'b0, 1'b0};
      vecs[6]  = '{2'd1, 1'b0, 1'b0, 24'h0,          4,   24'h000000, 1'b1, 1'b0};
      vecs[7]  = '{2'd0, 1'b1, 1'b1, {8'd0,8'd0,8'd2},    1, {8'd0,8'd0,8'd2},   1'b0, 1'b0};
      vecs[8]  = '{2'd1, 1'b1, 1'b0, 24'h0,          4,   {8'd0,8'd0,8'd1},   1'b1, 1'b0};
      vecs[9]  = '{2'd1, 1'b1, 1'b0, 24'h0,          4,   24'h000000, 1'b0, 1'b1};
      vecs[10] = '{2'd1, 1'b1, 1'b0, 24'h0,          100, 24'h000000, 1'b0, 1'b1};
      vecs[11] = '{2'd2, 1'b1, 1'b0, 24'h0,          1,   24'h000000, 1'b0, 1'b0};
      vecs[12] = '{2'd0, 1'b1, 1'b1, 24'hFFFFFF,     1,   {8'd59,8'd59,8'd99}, 1'b0, 1'b0};
      vecs[13] = '{2'd0, 1'b0, 1'b1, {8'd60,8'd30,8'd100}, 1, {8'd59,8'd30,8'd99}, 1'b0, 1'b0};
      vecs[14] = '{2'd1, 1'b0, 1'b0, 24'h0,          2,   {8'd59,8'd30,8'd99}, 1'b1, 1'b0};
      vecs[15] = '{2'd0, 1'b0, 1'b0, 24'h0,          50,  {8'd59,8'd30,8'd99}, 1'b0, 1'b0};
      vecs[16] = '{2'd1, 1'b0, 1'b0, 24'h0,          1,   {8'd59,8'd30,8'd99}, 1'b1, 1'b0};
      vecs[17] = '{2'd1, 1'b0, 1'b0, 24'h0,          1,   {8'd59,8'd31,8'd0},  1'b1, 1'b0};
      vecs[18] = '{2'd1, 1'b1, 1'b0, 24'h0,          4,   {8'd59,8'd30,8'd99}, 1'b1, 1'b0};
      vecs[19] = '{2'd0, 1'b1, 1'b1, {8'd1,8'd0,8'd0},    1, {8'd1,8'd0,8'd0},   1'b0, 1'b0};
      vecs[20] = '{2'd1, 1'b1, 1'b0, 24'h0,          4,   {8'd0,8'd59,8'd99}, 1'b1, 1'b0};
      vecs[21] = '{2'd1, 1'b1, 1'b0, 24'h0,          2,   {8'd0,8'd59,8'd99}, 1'b1, 1'b0};
      vecs[22] = '{2'd1, 1'b0, 1'b0, 24'h0,          2,   {8'd1,8'd0,8'd0},   1'b1, 1'b0};

      resetn = 1'b0; cmd = 2'd0; dir = 1'b0; load = 1'b0; load_val = 24'h0; lap_rd = 1'b0;
      #12 resetn = 1'b1;
      #1;
      check("reset_timer", timer, 24'h0);
      check("reset_lap_valid", {23'd0, lap_valid}, 24'd0);
      check("reset_lap_count", {21'd0, lap_count}, 24'd0);

      for (int i = 0; i < 23; i++) begin
         cmd = vecs[i].cmd; dir = vecs[i].dir; load = vecs[i].load; load_val = vecs[i].lv;
         step();
         load = 1'b0;
         repeat (vecs[i].ncyc - 1) step();
         check($sformatf("vec%0d_timer", i), timer, fmt(vecs[i].t));
         check($sformatf("vec%0d_running", i), {23'd0, running}, {23'd0, vecs[i].run});
         check($sformatf("vec%0d_expired", i), {23'd0, expired}, {23'd0, vecs[i].exp});
      end

      // Lap capture: five edges into a 4-deep FIFO while counting up from zero
      cmd = 2'd2; dir = 1'b0; step();
      check("clear_lap_count", {21'd0, lap_count}, 24'd0);
      n = 0;
      for (int p = 0; p < 5; p++) begin
         cmd = 2'd1;
         repeat ($urandom_range(1, 8)) begin step(); n++; end
         cmd = 2'd3;
         if (p < 4) exp_q.push_back({16'd0, 8'(n / 4)});
         step(); n++;
      end
      cmd = 2'd1; step(); n++;
      cmd = 2'd0; step();
      check("lap_count_full", {21'd0, lap_count}, 24'd4);
      check("lap_ovf_set", {23'd0, lap_ovf}, 24'd1);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("lap_valid_%0d", k), {23'd0, lap_valid}, 24'd1);
         e = exp_q.pop_front();
         check($sformatf("lap_data_%0d", k), lap_data, fmt(e));
         lap_rd = 1'b1; step(); lap_rd = 1'b0;
      end
      check("lap_valid_empty", {23'd0, lap_valid}, 24'd0);
      lap_rd = 1'b1; step(); lap_rd = 1'b0;
      check("lap_rd_empty_count", {21'd0, lap_count}, 24'd0);
      check("lap_ovf_sticky", {23'd0, lap_ovf}, 24'd1);

      // Load coinciding with a lap edge pushes the pre-load value
      exp_q.push_back({16'd0, 8'(n / 4)});
      cmd = 2'd3; load = 1'b1; load_val = {8'd0, 8'd0, 8'd77};
      step();
      load = 1'b0; cmd = 2'd0; step();
      check("load_lap_timer", timer, fmt({8'd0, 8'd0, 8'd77}));
      check("load_lap_count", {21'd0, lap_count}, 24'd1);
      e = exp_q.pop_front();
      check("load_lap_data", lap_data, fmt(e));

      // Asynchronous reset mid-countdown with three entries held
      cmd = 2'd2; step();
      cmd = 2'd0; dir = 1'b1; load = 1'b1; load_val = {8'd0, 8'd0, 8'd50}; step();
      load = 1'b0;
      for (int p = 0; p < 3; p++) begin
         cmd = 2'd1; step(); step();
         cmd = 2'd3; step();
      end
      cmd = 2'd1; step(); step();
      check("pre_reset_count", {21'd0, lap_count}, 24'd3);
      check("pre_reset_running", {23'd0, running}, 24'd1);
      @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      check("areset_timer", timer, 24'h0);
      check("areset_running", {23'd0, running}, 24'd0);
      check("areset_expired", {23'd0, expired}, 24'd0);
      check("areset_lap_data", lap_data, 24'h0);
      check("areset_lap_valid", {23'd0, lap_valid}, 24'd0);
      check("areset_lap_count", {21'd0, lap_count}, 24'd0);
      check("areset_lap_ovf", {23'd0, lap_ovf}, 24'd0);
      #10 resetn = 1'b1;

      // BCD/binary field encoding of a loaded value
      cmd = 2'd0; load = 1'b1; load_val = {8'd0, 8'd45, 8'd37}; step();
      load = 1'b0;
`ifdef STOPWATCH_BCD_OUT_EN
      e = 24'h004537;
`else
      e = 24'h002D25;
`endif
      check("encoding_004537", timer, e);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
